fsm_stim_driver: RTL
====================

Name: fsm_stim_driver

Overview:
- Companion controller for the three-phase sequence FSM: FIRST, then SECOND, then THIRD, then back to FIRST.
- Drives that FSM's restart and pause inputs from registers.
- Consumes its even, odd and terminal outputs to count completed sequences and flag mismatches against an internal shadow model.
- Sits beside the FSM in the same clock domain, in place of pins/VIO, for automated stress runs.

Parameters:
- CW, 16, width of sequence count and target.
- PW, 4, width of pause length.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a run from IDLE
- stop  input  1  one-cycle pulse; aborts a run
- num_seq  input  CW  sequences per run; 0 = run until stop
- pause_len  input  PW  pause cycles inserted per sequence in SECOND; 0 = none
- even  input  1  from FSM
- odd  input  1  from FSM
- terminal  input  1  from FSM
- restart  output  1  to FSM, registered
- pause  output  1  to FSM, registered
- busy  output  1  high in RUN/HOLD/FINISH
- done  output  1  one-cycle pulse at run completion
- seq_count  output  CW  terminal events counted in current run
- mismatch  output  1  one-cycle pulse on checker miscompare
- err  output  1  sticky mismatch flag; cleared by reset or start

Behaviour:
- Reset values (asynchronous): state=IDLE, restart=1, pause=0, busy=0, done=0, seq_count=0, mismatch=0, err=0, shadow=FIRST (2'b11), pcnt=0, paused_this_seq=0.
- Shadow model: 2-bit encoding FIRST=11, SECOND=10, THIRD=01. Each clock it applies the FSM transition rule to the current registered restart/pause:
  - FIRST: stays if restart|pause, else SECOND.
  - SECOND: restart gives FIRST; else pause stays; else THIRD.
  - THIRD: stays if !restart & pause, else FIRST.
  - Illegal 00 goes to FIRST.
- Expected outputs each cycle:
  - exp_even = (shadow==SECOND)
  - exp_odd = (shadow==FIRST or THIRD)
  - exp_term = (shadow==THIRD) & (restart | !pause)
- Checker (every cycle, all states): any difference between {even,odd,terminal} and expected gives mismatch=1 next cycle and sets err. err is cleared on start.
- States: IDLE, RUN, HOLD, FINISH.
- IDLE: restart=1, pause=0. start gives RUN next cycle, with restart=0, seq_count=0, err=0, busy=1. start while busy is ignored.
- RUN: restart=0. When shadow==SECOND, pause_len!=0 and paused_this_seq=0:
  - register pause=1, pcnt=pause_len, paused_this_seq=1;
  - go HOLD.
- HOLD: pause=1, pcnt decrements. The cycle pcnt==1, pause goes to 0 next cycle and the state returns to RUN.
  - Net effect: the FSM dwells in SECOND exactly 1+pause_len cycles.
- Sequence end: terminal==1 && shadow==THIRD sampled in RUN.
  - seq_count increments (wraps at 2^CW).
  - paused_this_seq clears.
  - If num_seq!=0 and seq_count+1==num_seq, go FINISH.
- FINISH (one cycle): restart=1, done=1, then IDLE with busy=0. seq_count holds its final value until the next start.
- stop in RUN/HOLD/FINISH: next cycle restart=1, pause=0, state=IDLE, busy=0, no done pulse. stop in IDLE is ignored.
- Simultaneous events:
  - start & stop in IDLE: start wins.
  - stop and terminal in the same cycle: count increments, then abort.
  - stop wins over FINISH.
- Reset mid-run: all outputs return to reset values immediately; restart=1 forces the FSM to FIRST on its next edge.

Optional Feature:
- Macro: FSM_STIM_ERR_COUNT_EN.
- Defined: adds output err_count (8 bits), a count of mismatch pulses that saturates at 255 and clears on reset or start. A mismatch also freezes the run: state goes to IDLE as for stop, so waveforms are preserved at the first fault.
- Undefined: no err_count port; the run continues after a mismatch, and only the mismatch/err flags are reported.

Test Plan:
- Reset, then start with num_seq=3, pause_len=0 -> FSM cycles 11,10,01 three times. seq_count reaches 3; done pulses once 9+1 cycles after start; err=0.
- num_seq=2, pause_len=4 -> pause high 4 cycles per sequence. even high 5 consecutive cycles per sequence; seq_count=2; err=0.
- num_seq=0, pause_len=1, stop after 20 cycles -> restart=1 the next cycle, busy=0, no done. seq_count equals the terminals observed.
- Force even low for one cycle mid-run -> mismatch pulses 1 cycle later, err stays 1 until next start. With FSM_STIM_ERR_COUNT_EN: err_count=1 and the run aborts.
- Assert rst_n low while in HOLD -> immediate restart=1, pause=0, busy=0. The FSM reads FIRST (odd=1) on the following edge.
- start and stop in the same cycle from IDLE -> run begins (busy=1); stop ignored.

Source files
------------

// File: rtl/fsm_stim_driver.sv
`default_nettype none
// ============================================================================
// Module      : fsm_stim_driver
// Description : Register-driven stimulus and checker for the three-phase
//               sequence FSM (FIRST -> SECOND -> THIRD -> FIRST). Drives the
//               FSM's restart/pause inputs, counts completed sequences and
//               compares the FSM's even/odd/terminal outputs against an
//               internal shadow model every cycle.
//               Optional: define FSM_STIM_ERR_COUNT_EN to add a saturating
//               8-bit err_count output and abort the run on first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_stim_driver #(
    parameter int CW = 16,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] num_seq,
    input  logic [PW-1:0] pause_len,
    input  logic          even,
    input  logic          odd,
    input  logic          terminal,
    output logic          restart,
    output logic          pause,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] seq_count,
    output logic          mismatch,
    output logic          err
`ifdef FSM_STIM_ERR_COUNT_EN
    ,
    output logic [7:0]    err_count
`endif
);

    // Controller states
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    // Shadow encoding of the observed FSM
    localparam logic [1:0] c_SH_FIRST  = 2'b11;
    localparam logic [1:0] c_SH_SECOND = 2'b10;
    localparam logic [1:0] c_SH_THIRD  = 2'b01;

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [1:0]    r_shadow;
    logic [1:0]    w_shadow_next;
    logic          r_restart;
    logic          r_pause;
    logic          r_done;
    logic          r_mismatch;
    logic          r_err;
    logic [CW-1:0] r_seq_count;
    logic [PW-1:0] r_pcnt;
    logic          r_paused;

    logic          w_restart_next;
    logic          w_pause_next;
    logic          w_done_next;
    logic          w_exp_even;
    logic          w_exp_odd;
    logic          w_exp_term;
    logic          w_diff;
    logic          w_busy;
    logic          w_start_ok;
    logic          w_abort;
    logic          w_term_evt;
    logic          w_last;
    logic          w_pause_go;
    logic          w_hold_end;

    // Shadow transition: mirrors the FSM, driven by the registered controls it sees
    always_comb begin
        w_shadow_next = c_SH_FIRST;
        case (r_shadow)
            c_SH_FIRST:  w_shadow_next = (r_restart | r_pause) ? c_SH_FIRST : c_SH_SECOND;
            c_SH_SECOND: w_shadow_next = r_restart ? c_SH_FIRST :
                                         (r_pause ? c_SH_SECOND : c_SH_THIRD);
            c_SH_THIRD:  w_shadow_next = (!r_restart && r_pause) ? c_SH_THIRD : c_SH_FIRST;
            default:     w_shadow_next = c_SH_FIRST;
        endcase
    end

    assign w_exp_even = (r_shadow == c_SH_SECOND);
    assign w_exp_odd  = (r_shadow == c_SH_FIRST) || (r_shadow == c_SH_THIRD);
    assign w_exp_term = (r_shadow == c_SH_THIRD) && (r_restart || !r_pause);
    assign w_diff     = ({even, odd, terminal} != {w_exp_even, w_exp_odd, w_exp_term});

    assign w_busy     = (r_state != c_ST_IDLE);
    assign w_start_ok = start && (r_state == c_ST_IDLE);
`ifdef FSM_STIM_ERR_COUNT_EN
    // A reported mismatch freezes the run exactly like a stop request
    assign w_abort    = w_busy && (stop || r_mismatch);
`else
    assign w_abort    = w_busy && stop;
`endif
    assign w_term_evt = (r_state == c_ST_RUN) && terminal && (r_shadow == c_SH_THIRD);
    assign w_last     = (num_seq != '0) && ((r_seq_count + CW'(1)) == num_seq);
    // Decide on the shadow's next state so pause is already high while the
    // FSM sits in SECOND; the dwell is then exactly 1+pause_len cycles.
    assign w_pause_go = (r_state == c_ST_RUN) && (w_shadow_next == c_SH_SECOND) &&
                        (pause_len != '0) && !r_paused;
    assign w_hold_end = (r_state == c_ST_HOLD) && (r_pcnt == PW'(1));

    // State register together with the registered FSM controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_restart <= 1'b1;
            r_pause   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_restart <= w_restart_next;
            r_pause   <= w_pause_next;
            r_done    <= w_done_next;
        end
    end

    // Next-state logic; abort (stop) outranks sequence completion
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_next = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_abort)                 w_state_next = c_ST_IDLE;
                else if (w_term_evt && w_last) w_state_next = c_ST_FINISH;
                else if (w_pause_go)         w_state_next = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (w_abort)         w_state_next = c_ST_IDLE;
                else if (w_hold_end) w_state_next = c_ST_RUN;
            end
            c_ST_FINISH: w_state_next = c_ST_IDLE;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Output decode from the next state: restart outside RUN/HOLD, pause in HOLD
    always_comb begin
        w_restart_next = 1'b1;
        w_pause_next   = 1'b0;
        w_done_next    = 1'b0;
        case (w_state_next)
            c_ST_RUN:    w_restart_next = 1'b0;
            c_ST_HOLD: begin
                w_restart_next = 1'b0;
                w_pause_next   = 1'b1;
            end
            c_ST_FINISH: w_done_next = 1'b1;
            default: begin
                w_restart_next = 1'b1;
                w_pause_next   = 1'b0;
            end
        endcase
    end

    // Shadow model, sequence counter, pause counter and checker flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= c_SH_FIRST;
            r_seq_count <= '0;
            r_pcnt      <= '0;
            r_paused    <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_shadow   <= w_shadow_next;
            r_mismatch <= w_diff;
            r_err      <= w_start_ok ? 1'b0 : (r_err | w_diff);

            if (w_start_ok)      r_seq_count <= '0;
            else if (w_term_evt) r_seq_count <= r_seq_count + CW'(1);

            if (w_start_ok || w_term_evt) r_paused <= 1'b0;
            else if (w_pause_go)          r_paused <= 1'b1;

            if (w_pause_go)                    r_pcnt <= pause_len;
            else if (w_state_next == c_ST_HOLD) r_pcnt <= r_pcnt - PW'(1);
            else                               r_pcnt <= '0;
        end
    end

`ifdef FSM_STIM_ERR_COUNT_EN
    logic [7:0] r_err_count;

    // Saturating count of mismatch pulses, cleared when a run starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_err_count <= 8'd0;
        else if (w_start_ok)                   r_err_count <= 8'd0;
        else if (w_diff && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end

    assign err_count = r_err_count;
`endif

    assign restart   = r_restart;
    assign pause     = r_pause;
    assign busy      = w_busy;
    assign done      = r_done;
    assign seq_count = r_seq_count;
    assign mismatch  = r_mismatch;
    assign err       = r_err;

endmodule
`default_nettype wire
